// File: rtl/lc3_pipe_ctrl.sv
// Pipeline control for the LC3 five-stage core: stage enables, memaccess
// sequencing, execute operand bypass selects and the branch-taken decision.
module lc3_pipe_ctrl #(
    parameter int unsigned BR_SHADOW = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IMem_dout,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state,
    output logic        br_taken
);

    localparam int unsigned CNT_W  = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);
    localparam int unsigned FILL_W = 3;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BR_SHADOW);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(4);

    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12;

    typedef enum logic [1:0] {
        MS_DATA_RD = 2'd0,
        MS_IND_RD  = 2'd1,
        MS_DATA_WR = 2'd2,
        MS_IDLE    = 2'd3
    } mem_state_e;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    mem_state_e        mem_state_q, mem_state_d;
    logic [3:0]        mem_op_q, mem_op_d;
    logic              mem_done_q, mem_done_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic en_updatepc_q, en_updatepc_d;
    logic en_fetch_q, en_fetch_d;
    logic en_decode_q, en_decode_d;
    logic en_execute_q, en_execute_d;
    logic en_writeback_q, en_writeback_d;

    logic byp_alu_1_q, byp_alu_1_d;
    logic byp_alu_2_q, byp_alu_2_d;
    logic byp_mem_1_q, byp_mem_1_d;
    logic byp_mem_2_q, byp_mem_2_d;

    logic [3:0] if_op, id_op, ex_op;
    logic [2:0] ex_dr;
    logic       src1_hit, src2_hit;
    logic       unused_bits;

    assign if_op = IMem_dout[15:12];
    assign id_op = IR[15:12];
    assign ex_op = IR_Exec[15:12];
    assign ex_dr = IR_Exec[11:9];

    assign unused_bits = ^{IMem_dout[11:0], IR[4:3], IR_Exec[8:0]};

    // Does the decoding instruction read the executing instruction's destination?
    always_comb begin
        src1_hit = (is_alu(id_op) || (id_op == OP_LDR) || (id_op == OP_STR) ||
                    (id_op == OP_JMP)) && (IR[8:6] == ex_dr);
        src2_hit = (is_alu(id_op) && !IR[5] && (IR[2:0] == ex_dr)) ||
                   (is_store(id_op) && (IR[11:9] == ex_dr));
    end

    always_comb begin
        mem_state_d    = mem_state_q;
        mem_op_d       = mem_op_q;
        mem_done_d     = mem_done_q;
        br_cnt_d       = br_cnt_q;
        fill_d         = fill_q;
        byp_alu_1_d    = byp_alu_1_q;
        byp_alu_2_d    = byp_alu_2_q;
        byp_mem_1_d    = byp_mem_1_q;
        byp_mem_2_d    = byp_mem_2_q;
        en_updatepc_d  = 1'b0;
        en_fetch_d     = 1'b0;
        en_decode_d    = 1'b0;
        en_execute_d   = 1'b0;
        en_writeback_d = 1'b0;

        if (complete_instr) begin
            mem_done_d = 1'b0;

            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end

            // The cycle after a memory op completes, IR_Exec still holds it; don't restart.
            unique case (mem_state_q)
                MS_IDLE: begin
                    if (!mem_done_q) begin
                        case (ex_op)
                            OP_LD, OP_LDR: begin
                                mem_state_d = MS_DATA_RD;
                                mem_op_d    = ex_op;
                            end
                            OP_ST, OP_STR: begin
                                mem_state_d = MS_DATA_WR;
                                mem_op_d    = ex_op;
                            end
                            OP_LDI, OP_STI: begin
                                mem_state_d = MS_IND_RD;
                                mem_op_d    = ex_op;
                            end
                            default: ;
                        endcase
                    end
                end
                MS_IND_RD: begin
                    if (complete_data) begin
                        mem_state_d = (mem_op_q == OP_STI) ? MS_DATA_WR : MS_DATA_RD;
                    end
                end
                MS_DATA_RD, MS_DATA_WR: begin
                    if (complete_data) begin
                        mem_state_d = MS_IDLE;
                        mem_done_d  = 1'b1;
                    end
                end
            endcase

            // Shadow counter: loads on a fetched BR/JMP, frozen while memory stalls.
            if (en_fetch_q && is_ctrl(if_op)) begin
                br_cnt_d = CNT_LOAD;
            end else if ((br_cnt_q != CNT_ZERO) && (mem_state_q == MS_IDLE)) begin
                br_cnt_d = br_cnt_q - CNT_ONE;
            end

            if (en_decode_q) begin
                byp_alu_1_d = is_alu(ex_op) && src1_hit;
                byp_alu_2_d = is_alu(ex_op) && src2_hit;
                byp_mem_1_d = is_load(ex_op) && src1_hit;
                byp_mem_2_d = is_load(ex_op) && src2_hit;
            end

            // Enables reflect the state the pipeline is entering.
            if (mem_state_d != MS_IDLE) begin
                en_writeback_d = (mem_state_d == MS_DATA_RD);
            end else if (br_cnt_d != CNT_ZERO) begin
                en_updatepc_d  = (br_cnt_d == CNT_ONE);
                en_decode_d    = (br_cnt_d == CNT_LOAD);
                en_execute_d   = (fill_d >= FILL_W'(3));
                en_writeback_d = (fill_d >= FILL_W'(4));
            end else begin
                en_updatepc_d  = (fill_d >= FILL_W'(1));
                en_fetch_d     = (fill_d >= FILL_W'(1));
                en_decode_d    = (fill_d >= FILL_W'(2));
                en_execute_d   = (fill_d >= FILL_W'(3));
                en_writeback_d = (fill_d >= FILL_W'(4));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_state_q    <= MS_IDLE;
            mem_op_q       <= 4'd0;
            mem_done_q     <= 1'b0;
            br_cnt_q       <= CNT_ZERO;
            fill_q         <= '0;
            en_updatepc_q  <= 1'b0;
            en_fetch_q     <= 1'b0;
            en_decode_q    <= 1'b0;
            en_execute_q   <= 1'b0;
            en_writeback_q <= 1'b0;
            byp_alu_1_q    <= 1'b0;
            byp_alu_2_q    <= 1'b0;
            byp_mem_1_q    <= 1'b0;
            byp_mem_2_q    <= 1'b0;
        end else begin
            mem_state_q    <= mem_state_d;
            mem_op_q       <= mem_op_d;
            mem_done_q     <= mem_done_d;
            br_cnt_q       <= br_cnt_d;
            fill_q         <= fill_d;
            en_updatepc_q  <= en_updatepc_d;
            en_fetch_q     <= en_fetch_d;
            en_decode_q    <= en_decode_d;
            en_execute_q   <= en_execute_d;
            en_writeback_q <= en_writeback_d;
            byp_alu_1_q    <= byp_alu_1_d;
            byp_alu_2_q    <= byp_alu_2_d;
            byp_mem_1_q    <= byp_mem_1_d;
            byp_mem_2_q    <= byp_mem_2_d;
        end
    end

    assign enable_updatePC  = en_updatepc_q;
    assign enable_fetch     = en_fetch_q;
    assign enable_decode    = en_decode_q;
    assign enable_execute   = en_execute_q;
    assign enable_writeback = en_writeback_q;
    assign bypass_alu_1     = byp_alu_1_q;
    assign bypass_alu_2     = byp_alu_2_q;
    assign bypass_mem_1     = byp_mem_1_q;
    assign bypass_mem_2     = byp_mem_2_q;
    assign mem_state        = 2'(mem_state_q);
    assign br_taken         = (br_cnt_q == CNT_ONE) && (|(NZP & psr));

endmodule

// File: doc/lc3_pipe_ctrl.md
# lc3_pipe_ctrl

Pipeline control unit for the LC3 five-stage core (fetch, decode, execute, memaccess, writeback). Produces the per-stage enables, the memaccess state sequence for LD/LDR/LDI/ST/STR/STI, the operand bypass selects for execute, and the branch-taken decision. It receives instruction words from decode/execute/instruction memory and status from execute/writeback, and drives every stage enable in the core.

## Interface
Parameters:
- BR_SHADOW, 3: cycles with fetch suppressed after a control instruction (BR/JMP) is fetched.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- complete_instr  in  1  instruction memory returned valid data; low freezes all state and deasserts all enables
- complete_data  in  1  data memory access done; mem_state advances only when high
- IMem_dout  in  16  word at fetch
- IR  in  16  instruction in decode
- IR_Exec  in  16  instruction in execute
- NZP  in  3  branch condition mask from execute (111 for JMP)
- psr  in  3  current N/Z/P flags from writeback
- enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables
- bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  execute operand forwarding selects
- mem_state  out  2  memaccess state: 3 idle, 1 indirect-address read, 0 data read, 2 data write
- br_taken  out  1  PC load from taddr

## Operation
- Opcodes: ALU = ADD 1, AND 5, NOT 9; loads = LD 2, LDR 6, LDI 10; stores = ST 3, STR 7, STI 11; control = BR 0, JMP 12.
- Priority: reset > complete_instr low > memory stall > branch shadow > pipeline fill > normal (all enables 1).
- Pipeline fill after reset release: cycle 1 updatePC+fetch; cycle 2 adds decode; cycle 3 adds execute; cycle 4 adds writeback. Fill counter saturates.
- mem_state FSM (registered): 3→0 when IR_Exec is LD/LDR; 3→2 for ST/STR; 3→1 for LDI/STI; 1→0 (LDI) or 1→2 (STI); 0→3; 2→3. Every transition out of 0/1/2 requires complete_data=1, else hold. Opcode latched on leaving 3.
- Memory stall (mem_state≠3): updatePC, fetch, decode, execute = 0; writeback = 1 only in state 0, else 0. Stores: writeback 0 in state 2. Cycle mem_state returns to 3: all enables 1.
- Branch shadow: when enable_fetch=1 and IMem_dout[15:12] ∈ {0,12}, counter loads BR_SHADOW. While counter ≠0: fetch=0; decode=0 except at count=BR_SHADOW; updatePC=1 only at count=1; counter decrements each cycle (frozen during memory stall). Execute/writeback follow normal timing.
- br_taken = (count==1) & |(NZP & psr); 0 at all other times.
- Bypass (registered; updated when enable_decode=1, held when 0, cleared by reset). dr = IR_Exec[11:9].
  - bypass_alu_1: IR_Exec ALU, IR ∈ ALU/LDR/STR/JMP, IR[8:6]==dr.
  - bypass_alu_2: IR_Exec ALU and either (IR ALU, IR[5]=0, IR[2:0]==dr) or (IR store, IR[11:9]==dr).
  - bypass_mem_1/2: same rules with IR_Exec a load.

## Timing
- Reset (reset=0 at edge): all enables 0, bypass_* 0, mem_state 3, br_taken 0, counters 0. Mid-operation reset aborts any memory sequence or shadow; fill restarts.
- Enables and mem_state are registered; each takes effect the cycle after its cause. br_taken is combinational from registered count.
- complete_data low in state 1 holds state 1 and all enables indefinitely.
- Control instruction fetched while IR_Exec is a load: memory stall wins; shadow count freezes, resumes after return to 3.
- Back-to-back control instructions: detection blocked (fetch=0) during shadow.

## Test plan
- Reset 3 cycles, release -> enables rise in fill order over cycles 1-4; mem_state=3, bypass 0.
- LDI in execute, complete_data=1 -> mem_state 3,1,0,3; writeback 1 only in state-0 cycle; fetch 0 for two cycles.
- STI with complete_data low for 2 cycles in state 1 -> mem_state 3,1,1,1,2,3; enables held 0 throughout.
- ADD R1,R2,R3 executing, ADD R4,R1,R1 decoding -> next cycle bypass_alu_1=1, bypass_alu_2=1; LD R1 instead -> bypass_mem_1/2=1.
- BRz with psr=010, NZP=010 -> fetch 0 for 3 cycles, br_taken=1 exactly at count 1 with updatePC=1; psr=100 -> br_taken 0.
- reset asserted in mem_state 1 -> next cycle mem_state 3, all outputs reset values.
